// File: rtl/mips_sram_ctrl_pkg.sv
// Shared types and defaults for the MIPS SRAM responder: state encoding,
// parameter defaults, byte-lane constants and the wait-counter width helper.
package mips_sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WSETUP,
        WPULSE,
        WHOLD,
        DRD,
        IRD,
        DONE
    } state_e;

    localparam int unsigned ADDR_W_DEF  = 18;
    localparam int unsigned RD_WAIT_DEF = 1;
    localparam int unsigned WR_WAIT_DEF = 1;

    localparam logic [3:0] BE_ALL_N  = 4'b0000;
    localparam logic [3:0] BE_NONE_N = 4'b1111;

    // Zero wait states still need a one-bit counter to stay legal.
    function automatic int unsigned cnt_width(input int unsigned rd, input int unsigned wr);
        int unsigned mx;
        mx = (rd > wr) ? rd : wr;
        return (mx == 0) ? 1 : $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/mips_sram_ctrl_if.sv
// Core-side instruction/data port of the MIPS SRAM responder.
interface mips_sram_ctrl_if;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic [3:0]  bwe;
    logic        data_re;
    logic [31:0] data_in;
    logic        mem_wait;

    modport master (
        output inst_addr, data_addr, data_out, bwe, data_re,
        input  inst, data_in, mem_wait
    );

    modport slave (
        input  inst_addr, data_addr, data_out, bwe, data_re,
        output inst, data_in, mem_wait
    );
endinterface

// File: rtl/mips_sram_wait_cnt.sv
// Loadable down-counter with zero flag; times the SRAM read strobe and write pulse.
module mips_sram_wait_cnt #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mips_sram_ctrl.sv
// Serves the MIPS core's data and fetch ports from one asynchronous 32-bit SRAM.
// Optional MIPS_SRAM_FETCH_BUF_EN adds a one-entry fetch buffer that skips repeat fetches.
module mips_sram_ctrl
    import mips_sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned RD_WAIT = RD_WAIT_DEF,
    parameter int unsigned WR_WAIT = WR_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    mips_sram_ctrl_if.slave   core,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_dq_o,
    input  logic [31:0]       sram_dq_i,
    output logic              sram_dq_oe_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o
);
    localparam int unsigned CW = cnt_width(RD_WAIT, WR_WAIT);
    localparam logic [CW-1:0] RD_LD = CW'(RD_WAIT);
    localparam logic [CW-1:0] WR_LD = CW'(WR_WAIT);

    state_e state_q, state_d;
    logic [ADDR_W-1:0] ia_q, ia_d, da_q, da_d;
    logic [31:0] wd_q, wd_d;
    logic [3:0]  bwe_q, bwe_d;
    logic        re_q, re_d;
    logic        cnt_zero, cnt_load, fb_hit;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0] dq_q, dq_d, inst_q, inst_d, din_q, din_d;
    logic        dq_oe_q, dq_oe_d, ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic        wait_q, wait_d;
    logic [3:0]  be_n_q, be_n_d;

    // Request is sampled only in IDLE and held for the rest of the cycle.
    always_comb begin
        ia_d  = ia_q;
        da_d  = da_q;
        wd_d  = wd_q;
        bwe_d = bwe_q;
        re_d  = re_q;
        if (state_q == IDLE) begin
            ia_d  = core.inst_addr[ADDR_W+1:2];
            da_d  = core.data_addr[ADDR_W+1:2];
            wd_d  = core.data_out;
            bwe_d = core.bwe;
            re_d  = core.data_re;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ia_q    <= '0;
            da_q    <= '0;
            wd_q    <= '0;
            bwe_q   <= '0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ia_q    <= ia_d;
            da_q    <= da_d;
            wd_q    <= wd_d;
            bwe_q   <= bwe_d;
            re_q    <= re_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (|bwe_d)      state_d = WSETUP;
                else if (re_d)   state_d = DRD;
                else if (fb_hit) state_d = DONE;
                else             state_d = IRD;
            end
            WSETUP:  state_d = WPULSE;
            WPULSE:  if (cnt_zero) state_d = WHOLD;
            WHOLD:   state_d = IRD;
            DRD:     if (cnt_zero) state_d = IRD;
            IRD:     if (cnt_zero) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cnt_load = (state_d != state_q) &&
                      (state_d == WPULSE || state_d == DRD || state_d == IRD);

    mips_sram_wait_cnt #(.W(CW)) u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i ((state_d == WPULSE) ? WR_LD : RD_LD),
        .zero_o     (cnt_zero)
    );

    // Outputs are decoded from the next state so every pin is a flop.
    always_comb begin
        addr_d  = addr_q;
        dq_d    = dq_q;
        dq_oe_d = 1'b0;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = BE_NONE_N;
        wait_d  = 1'b1;
        inst_d  = inst_q;
        din_d   = din_q;
        unique case (state_d)
            WSETUP, WPULSE, WHOLD: begin
                addr_d  = da_d;
                dq_d    = wd_d;
                dq_oe_d = 1'b1;
                ce_n_d  = 1'b0;
                be_n_d  = ~bwe_d;
                we_n_d  = (state_d != WPULSE);
            end
            DRD: begin
                addr_d = da_d;
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = BE_ALL_N;
            end
            IRD: begin
                addr_d = ia_d;
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = BE_ALL_N;
            end
            DONE:    wait_d = 1'b0;
            default: ;
        endcase
        if (state_q == DRD && cnt_zero) din_d  = sram_dq_i;
        if (state_q == IRD && cnt_zero) inst_d = sram_dq_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            dq_q    <= '0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            be_n_q  <= BE_NONE_N;
            wait_q  <= 1'b1;
            inst_q  <= '0;
            din_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            dq_oe_q <= dq_oe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            be_n_q  <= be_n_d;
            wait_q  <= wait_d;
            inst_q  <= inst_d;
            din_q   <= din_d;
        end
    end

`ifdef MIPS_SRAM_FETCH_BUF_EN
    logic [ADDR_W-1:0] fb_addr_q;
    logic              fb_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_addr_q  <= '0;
            fb_valid_q <= 1'b0;
        end else if (state_q != WSETUP && state_d == WSETUP) begin
            fb_valid_q <= 1'b0;
        end else if (state_q == IRD && cnt_zero) begin
            fb_addr_q  <= ia_q;
            fb_valid_q <= 1'b1;
        end
    end

    assign fb_hit = fb_valid_q && (fb_addr_q == ia_d);
`else
    assign fb_hit = 1'b0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && state_q == IDLE && (|core.bwe) && core.data_re)
            $warning("mips_sram_ctrl: store and load requested together, load dropped");
    end
`endif

    assign core.inst     = inst_q;
    assign core.data_in  = din_q;
    assign core.mem_wait = wait_q;
    assign sram_addr_o   = addr_q;
    assign sram_dq_o     = dq_q;
    assign sram_dq_oe_o  = dq_oe_q;
    assign sram_ce_n_o   = ce_n_q;
    assign sram_oe_n_o   = oe_n_q;
    assign sram_we_n_o   = we_n_q;
    assign sram_be_n_o   = be_n_q;
endmodule

// File: tb/tb_mips_sram_ctrl.sv
// Directed bench for mips_sram_ctrl with a behavioural asynchronous SRAM.
module tb_mips_sram_ctrl;
    import mips_sram_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] sram_addr;
    logic [31:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;
    logic [31:0] mem [0:255];

    int n_chk  = 0;
    int n_pass = 0;

    int          cyc, oe_lo, we_lo, dqoe_hi, ovl;
    logic [31:0] rd_addr, wr_addr, r_inst, r_din;
    logic [3:0]  wr_be;

    mips_sram_ctrl_if bus();

    mips_sram_ctrl #(.ADDR_W(18), .RD_WAIT(1), .WR_WAIT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .core         (bus),
        .sram_addr_o  (sram_addr),
        .sram_dq_o    (sram_dq_o),
        .sram_dq_i    (sram_dq_i),
        .sram_dq_oe_o (sram_dq_oe),
        .sram_ce_n_o  (sram_ce_n),
        .sram_oe_n_o  (sram_oe_n),
        .sram_we_n_o  (sram_we_n),
        .sram_be_n_o  (sram_be_n)
    );

    always #5 clk = ~clk;

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe)
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called at a falling edge while the DUT sits in IDLE; returns at the next IDLE.
    task automatic txn(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dout,
                       input logic [3:0] be, input logic re);
        bit done;
        bus.inst_addr = ia;
        bus.data_addr = da;
        bus.data_out  = dout;
        bus.bwe       = be;
        bus.data_re   = re;
        cyc = 1; oe_lo = 0; we_lo = 0; dqoe_hi = 0; ovl = 0;
        rd_addr = '1; wr_addr = '1; wr_be = 4'hx;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            cyc++;
            if (!sram_oe_n) begin oe_lo++; rd_addr = 32'(sram_addr); end
            if (!sram_we_n) begin we_lo++; wr_addr = 32'(sram_addr); wr_be = sram_be_n; end
            if (sram_dq_oe) dqoe_hi++;
            if (sram_dq_oe && !sram_oe_n) ovl++;
            if (!bus.mem_wait) begin
                done   = 1'b1;
                r_inst = bus.inst;
                r_din  = bus.data_in;
            end
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("wait_one_cycle", 32'(bus.mem_wait), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4]    = 32'h24080005;
        mem[5]    = 32'h00851020;
        mem[6]    = 32'h3C01ABCD;
        mem[8'h41] = 32'h11111111;
        bus.inst_addr = '0; bus.data_addr = '0; bus.data_out = '0;
        bus.bwe = '0; bus.data_re = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_wait",  32'(bus.mem_wait), 32'd1);
        check("rst_inst",  bus.inst, 32'h0);
        check("rst_din",   bus.data_in, 32'h0);
        check("rst_addr",  32'(sram_addr), 32'h0);
        check("rst_be_n",  32'(sram_be_n), 32'hF);
        check("rst_ctl",   {28'h0, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        rst = 1'b0;

        txn(32'h10, 32'h0, 32'h0, 4'h0, 1'b0);
        check("fetch_cyc",  32'(cyc), 32'd4);
        check("fetch_oe",   32'(oe_lo), 32'd2);
        check("fetch_addr", rd_addr, 32'h4);
        check("fetch_inst", r_inst, 32'h24080005);

        txn(32'h10, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0);
        check("sw_cyc",   32'(cyc), 32'd8);
        check("sw_we",    32'(we_lo), 32'd2);
        check("sw_dqoe",  32'(dqoe_hi), 32'd4);
        check("sw_be",    32'(wr_be), 32'h0);
        check("sw_addr",  wr_addr, 32'h40);
        check("sw_mem",   mem[8'h40], 32'hDEADBEEF);
        check("sw_ovl",   32'(ovl), 32'd0);
        check("sw_inst",  r_inst, 32'h24080005);

        txn(32'h10, 32'h100, 32'h0000AB00, 4'b0010, 1'b0);
        check("sb_be",  32'(wr_be), 32'hD);
        check("sb_mem", mem[8'h40], 32'hDEADABEF);

        txn(32'h14, 32'h100, 32'h0, 4'h0, 1'b1);
        check("lw_cyc",  32'(cyc), 32'd6);
        check("lw_oe",   32'(oe_lo), 32'd4);
        check("lw_din",  r_din, 32'hDEADABEF);
        check("lw_inst", r_inst, 32'h00851020);

        txn(32'h10, 32'h104, 32'h0000CAFE, 4'h3, 1'b1);
        check("cf_cyc",  32'(cyc), 32'd8);
        check("cf_oe",   32'(oe_lo), 32'd2);
        check("cf_be",   32'(wr_be), 32'hC);
        check("cf_mem",  mem[8'h41], 32'h1111CAFE);
        check("cf_din",  r_din, 32'hDEADABEF);
        check("cf_inst", r_inst, 32'h24080005);

        txn(32'h10, 32'h0, 32'h0, 4'h0, 1'b0);
`ifdef MIPS_SRAM_FETCH_BUF_EN
        check("fb_cyc", 32'(cyc), 32'd2);
        check("fb_oe",  32'(oe_lo), 32'd0);
`else
        check("fb_cyc", 32'(cyc), 32'd4);
        check("fb_oe",  32'(oe_lo), 32'd2);
`endif
        check("fb_inst", r_inst, 32'h24080005);

        txn(32'h0100_0018, 32'h0, 32'h0, 4'h0, 1'b0);
        check("wrap_cyc",  32'(cyc), 32'd4);
        check("wrap_addr", rd_addr, 32'h6);
        check("wrap_inst", r_inst, 32'h3C01ABCD);

        bus.inst_addr = 32'h10; bus.data_addr = 32'h104;
        bus.data_out = 32'h55555555; bus.bwe = 4'hF; bus.data_re = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_we", 32'(sram_we_n), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_we",    32'(sram_we_n), 32'd1);
        check("arst_dqoe",  32'(sram_dq_oe), 32'd0);
        check("arst_ce",    32'(sram_ce_n), 32'd1);
        check("arst_wait",  32'(bus.mem_wait), 32'd1);
        check("arst_inst",  bus.inst, 32'h0);
        check("arst_state", 32'(dut.state_q), 32'(IDLE));
        bus.bwe = 4'h0;
        @(negedge clk);
        rst = 1'b0;

        txn(32'h10, 32'h0, 32'h0, 4'h0, 1'b0);
        check("post_cyc",  32'(cyc), 32'd4);
        check("post_inst", r_inst, 32'h24080005);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
